// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: loads a 16-word block, runs one SHA-256 round per clock and chains the digest.
// Optional SHA_CTRL_SHA224_EN adds a mode224 port selecting the SHA-224 IV and a truncated digest.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         first_blk,
`ifdef SHA_CTRL_SHA224_EN
    input  logic         mode224,
`endif
    output logic         busy,
    output logic [5:0]   round_idx,
    output logic         digest_valid,
    output logic [255:0] digest,
    input  logic         digest_ack
);
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [5:0]   LAST  = 6'(NUM_ROUNDS - 1);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction
    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [5:0]        t_q, round_q;
    logic              first_q, in_ready_q, busy_q, dv_q;
    logic [255:0]      digest_q;
    // w_q[0] is the oldest word; s_q[7] is a, s_q[0] is h; h_q[7] is H0
    logic [15:0][31:0] w_q;
    logic [7:0][31:0]  s_q, h_q, s_d, h_sum;
    logic [31:0]       w_new, t1, t2;
    logic [255:0]      iv, h_init, dig_d;

`ifdef SHA_CTRL_SHA224_EN
    logic m224_q;
    assign iv    = m224_q ? IV224 : IV256;
    assign dig_d = {h_sum[7:1], m224_q ? 32'h0 : h_sum[0]};
`else
    assign iv    = IV256;
    assign dig_d = h_sum;
`endif

    always_comb begin
        w_new  = (t_q < 6'd16) ? w_q[0] : sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
        t1     = s_q[0] + bsig1(s_q[3]) + ch(s_q[3], s_q[2], s_q[1]) + K[t_q] + w_new;
        t2     = bsig0(s_q[7]) + maj(s_q[7], s_q[6], s_q[5]);
        s_d    = {t1 + t2, s_q[7:5], s_q[4] + t1, s_q[3:1]};
        h_init = first_q ? iv : h_q;
        for (int i = 0; i < 8; i++)
            h_sum[i] = h_q[i] + s_q[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            t_q        <= 6'd0;
            first_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            round_q    <= 6'd0;
            dv_q       <= 1'b0;
            digest_q   <= '0;
            h_q        <= IV256;
`ifdef SHA_CTRL_SHA224_EN
            m224_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    w_q     <= {in_data, w_q[15:1]};
                    first_q <= first_blk;
`ifdef SHA_CTRL_SHA224_EN
                    m224_q  <= mode224;
`endif
                    cnt_q   <= 4'd1;
                    state_q <= LOAD;
                end
                LOAD: if (in_valid) begin
                    w_q   <= {in_data, w_q[15:1]};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        h_q        <= h_init;
                        s_q        <= h_init;
                        t_q        <= 6'd0;
                        round_q    <= 6'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    w_q     <= {w_new, w_q[15:1]};
                    s_q     <= s_d;
                    t_q     <= t_q + 6'd1;
                    round_q <= (t_q == LAST) ? 6'd0 : t_q + 6'd1;
                    state_q <= (t_q == LAST) ? FINAL : ROUND;
                end
                FINAL: begin
                    h_q      <= h_sum;
                    digest_q <= dig_d;
                    busy_q   <= 1'b0;
                    dv_q     <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: if (digest_ack) begin
                    dv_q       <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q & reset_n;
    assign busy         = busy_q;
    assign round_idx    = round_q;
    assign digest_valid = dv_q;
    assign digest       = digest_q;
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: directed SHA-256 block vectors plus handshake, stall and reset corner cases.
module tb_sha256_round_ctrl;
    logic         clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, first_blk = 1'b0, digest_ack = 1'b0;
    logic [31:0]  in_data = 32'h0;
    logic         in_ready, busy, digest_valid;
    logic [5:0]   round_idx;
    logic [255:0] digest;
`ifdef SHA_CTRL_SHA224_EN
    logic         mode224 = 1'b0;
`endif

    sha256_round_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .first_blk(first_blk),
`ifdef SHA_CTRL_SHA224_EN
        .mode224(mode224),
`endif
        .busy(busy), .round_idx(round_idx), .digest_valid(digest_valid), .digest(digest),
        .digest_ack(digest_ack)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [15:0][31:0] w;
        logic              fb;
        logic              chk;
        logic [255:0]      exp;
    } vec_t;

    int errors = 0, checks = 0, acc_cnt = 0;

    always @(negedge clk) if (in_valid && in_ready) acc_cnt++;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_block(input logic [15:0][31:0] w, input logic fb, input bit gaps, input bit hold);
        int  i = 0;
        int  g = 0;
        bit  acc;
        digest_ack = hold;
        while (i < 16 && g < 2000) begin
            in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data   = in_valid ? w[i] : 32'hdeadbeef;
            first_blk = fb;
            acc       = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            g++;
        end
        in_valid = hold;
        in_data  = 32'hffffffff;
        check("post_load_state", 256'({busy, in_ready, round_idx}), 256'({1'b1, 1'b0, 6'd0}));
    endtask

    task automatic wait_done(input bit hold, output int lat, output logic [5:0] r10);
        lat = 0;
        r10 = 6'h3f;
        while (!digest_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) r10 = round_idx;
            if (hold && lat == 40) digest_ack = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic ack_digest(input string name);
        digest_ack = 1'b1;
        @(posedge clk); #1;
        digest_ack = 1'b0;
        check({name, "_after_ack"}, 256'({digest_valid, in_ready, busy}), 256'(3'b010));
    endtask

    initial begin
        vec_t              tbl [4];
        logic [15:0][31:0] abc;
        int                lat, c0, n;
        logic [5:0]        r10;
        logic [255:0]      snap;
        bit                stable;

        abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
        tbl[0] = '{w: abc, fb: 1'b1, chk: 1'b1, exp: D_ABC};
        tbl[1] = '{w: '0, fb: 1'b1, chk: 1'b1, exp: D_EMPTY};
        tbl[1].w[0] = 32'h80000000;
        tbl[2] = '{w: '{32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70, 32'h6c6d6e6f, 32'h6b6c6d6e,
                        32'h6a6b6c6d, 32'h696a6b6c, 32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
                        32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364},
                   fb: 1'b1, chk: 1'b0, exp: '0};
        tbl[3] = '{w: '0, fb: 1'b0, chk: 1'b1, exp: D_TWO};
        tbl[3].w[15] = 32'h000001c0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {250'(in_ready), busy, round_idx[4:0]}, '0);
        check("reset_round_dv", 256'({round_idx, digest_valid}), '0);
        check("reset_digest", digest, '0);
        reset_n = 1'b1;
        #1;
        check("ready_after_reset", 256'(in_ready), 256'(1));
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            c0 = acc_cnt;
            load_block(tbl[k].w, tbl[k].fb, 1'b0, 1'b0);
            wait_done(1'b0, lat, r10);
            check($sformatf("vec%0d_latency", k), 256'(lat), 256'(65));
            check($sformatf("vec%0d_round10", k), 256'(r10), 256'(10));
            check($sformatf("vec%0d_words", k), 256'(acc_cnt - c0), 256'(16));
            check($sformatf("vec%0d_done_flags", k), 256'({digest_valid, busy, in_ready}), 256'(3'b100));
            if (tbl[k].chk) check($sformatf("vec%0d_digest", k), digest, tbl[k].exp);
            ack_digest($sformatf("vec%0d", k));
        end

        c0 = acc_cnt;
        load_block(abc, 1'b1, 1'b1, 1'b1);
        wait_done(1'b1, lat, r10);
        check("bp_latency", 256'(lat), 256'(65));
        check("bp_words", 256'(acc_cnt - c0), 256'(16));
        check("bp_digest", digest, D_ABC);
        snap = digest;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (digest !== snap || digest_valid !== 1'b1) stable = 1'b0;
        end
        check("ack_low_stable", 256'(stable), 256'(1));
        ack_digest("bp");

        load_block(abc, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (round_idx != 6'd30 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_round30", 256'(round_idx), 256'(30));
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_flags", 256'({busy, digest_valid, in_ready, round_idx}), '0);
        check("midreset_digest", digest, '0);
        reset_n = 1'b1;
        #1;
        check("midreset_ready", 256'(in_ready), 256'(1));
        load_block(abc, 1'b0, 1'b0, 1'b0);
        wait_done(1'b0, lat, r10);
        check("post_reset_latency", 256'(lat), 256'(65));
        check("post_reset_digest", digest, D_ABC);
        ack_digest("post_reset");

`ifdef SHA_CTRL_SHA224_EN
        mode224 = 1'b1;
        load_block(abc, 1'b1, 1'b0, 1'b0);
        mode224 = 1'b0;
        wait_done(1'b0, lat, r10);
        check("sha224_digest", digest,
              256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
        ack_digest("sha224");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
